// File: rtl/sdma_ts_event_gen.sv
// sdma_ts_event_gen
//   Tracks outstanding DMA jobs per channel and turns busy-period edges into
//   single-cycle start/end pulses for the timestamp logger.
//
// Ports
//   i_clk        block clock
//   i_rst_n      asynchronous active-low reset
//   i_enable     gates start/end pulse generation (tracking always runs)
//   i_clear      synchronous clear of counters and sticky errors
//   i_cmd_valid  per-channel job command valid
//   i_cmd_ready  per-channel job command ready (accept = valid & ready)
//   i_done       per-channel single-cycle job-completion pulse
//   o_ts_start   registered busy-period start pulse
//   o_ts_end     registered busy-period end pulse
//   o_busy       registered, high while the outstanding count is non-zero
//   o_err_ovf    sticky: accept while the counter was saturated
//   o_err_udf    sticky: done while the counter was zero

package timestamp_logger_sdma_pkg;
    parameter int unsigned TimeLogNumDevs = 4;
endpackage

module sdma_ts_event_gen #(
    parameter int unsigned NumDevs = timestamp_logger_sdma_pkg::TimeLogNumDevs,
    parameter int unsigned OutstW  = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_clear,
    input  logic [NumDevs-1:0] i_cmd_valid,
    input  logic [NumDevs-1:0] i_cmd_ready,
    input  logic [NumDevs-1:0] i_done,
    output logic [NumDevs-1:0] o_ts_start,
    output logic [NumDevs-1:0] o_ts_end,
    output logic [NumDevs-1:0] o_busy,
    output logic [NumDevs-1:0] o_err_ovf,
    output logic [NumDevs-1:0] o_err_udf
);

    localparam logic [OutstW-1:0] CntMax  = '1;
    localparam logic [OutstW-1:0] CntZero = '0;
    localparam logic [OutstW-1:0] CntOne  = {{(OutstW-1){1'b0}}, 1'b1};

    logic [OutstW-1:0]  r_cnt [NumDevs];
    logic [OutstW-1:0]  w_cnt_d [NumDevs];
    logic [NumDevs-1:0] r_start, r_end, r_busy, r_err_ovf, r_err_udf;
    logic [NumDevs-1:0] w_start_d, w_end_d, w_busy_d, w_ovf_d, w_udf_d;
    logic [NumDevs-1:0] w_accept;

    assign w_accept = i_cmd_valid & i_cmd_ready;

    always_comb begin
        for (int unsigned i = 0; i < NumDevs; i++) begin
            w_cnt_d[i] = r_cnt[i];
            w_ovf_d[i] = r_err_ovf[i];
            w_udf_d[i] = r_err_udf[i];
            if (i_clear) begin
                w_cnt_d[i] = CntZero;
                w_ovf_d[i] = 1'b0;
                w_udf_d[i] = 1'b0;
            end else begin
                case ({w_accept[i], i_done[i]})
                    2'b10: begin
                        if (r_cnt[i] == CntMax) begin
                            w_ovf_d[i] = 1'b1;
                        end else begin
                            w_cnt_d[i] = r_cnt[i] + CntOne;
                        end
                    end
                    2'b01: begin
                        if (r_cnt[i] == CntZero) begin
                            w_udf_d[i] = 1'b1;
                        end else begin
                            w_cnt_d[i] = r_cnt[i] - CntOne;
                        end
                    end
                    2'b11: begin
                        // A done with nothing outstanding is an underflow; the
                        // accept still opens a busy period.
                        if (r_cnt[i] == CntZero) begin
                            w_cnt_d[i] = CntOne;
                            w_udf_d[i] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            w_busy_d[i]  = (w_cnt_d[i] != CntZero);
            // Clear aborts busy periods silently, so pulses are masked by it.
            w_start_d[i] = i_enable && !i_clear && (r_cnt[i] == CntZero)
                           && (w_cnt_d[i] != CntZero);
            w_end_d[i]   = i_enable && !i_clear && (r_cnt[i] != CntZero)
                           && (w_cnt_d[i] == CntZero);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NumDevs; i++) begin
                r_cnt[i] <= CntZero;
            end
            r_start   <= '0;
            r_end     <= '0;
            r_busy    <= '0;
            r_err_ovf <= '0;
            r_err_udf <= '0;
        end else begin
            for (int unsigned i = 0; i < NumDevs; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
            r_start   <= w_start_d;
            r_end     <= w_end_d;
            r_busy    <= w_busy_d;
            r_err_ovf <= w_ovf_d;
            r_err_udf <= w_udf_d;
        end
    end

    assign o_ts_start = r_start;
    assign o_ts_end   = r_end;
    assign o_busy     = r_busy;
    assign o_err_ovf  = r_err_ovf;
    assign o_err_udf  = r_err_udf;

endmodule

// File: tb/tb_sdma_ts_event_gen.sv
module tb_sdma_ts_event_gen;

    localparam int NumDevs = 4;
    localparam int OutstW  = 4;
    localparam int CntMax  = (1 << OutstW) - 1;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               clear;
    logic [NumDevs-1:0] cmd_valid;
    logic [NumDevs-1:0] cmd_ready;
    logic [NumDevs-1:0] done;
    logic [NumDevs-1:0] ts_start, ts_end, busy, err_ovf, err_udf;

    int n_total = 0;
    int n_pass  = 0;

    sdma_ts_event_gen #(
        .NumDevs (NumDevs),
        .OutstW  (OutstW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .i_clear     (clear),
        .i_cmd_valid (cmd_valid),
        .i_cmd_ready (cmd_ready),
        .i_done      (done),
        .o_ts_start  (ts_start),
        .o_ts_end    (ts_end),
        .o_busy      (busy),
        .o_err_ovf   (err_ovf),
        .o_err_udf   (err_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: an integer job count per channel plus the rules
    // for what each cycle's events mean.
    int m_cnt [NumDevs];
    bit m_ovf [NumDevs];
    bit m_udf [NumDevs];
    bit m_start [NumDevs];
    bit m_end [NumDevs];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumDevs; i++) begin
                m_cnt[i] <= 0; m_ovf[i] <= 0; m_udf[i] <= 0;
                m_start[i] <= 0; m_end[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NumDevs; i++) begin
                automatic int c   = m_cnt[i];
                automatic int acc = int'(cmd_valid[i] & cmd_ready[i]);
                automatic int dn  = int'(done[i]);
                automatic int n;
                if (clear) begin
                    m_cnt[i] <= 0; m_ovf[i] <= 0; m_udf[i] <= 0;
                    m_start[i] <= 0; m_end[i] <= 0;
                end else begin
                    n = c + acc - dn;
                    if (acc == 1 && dn == 1 && c == 0) n = 1;
                    if (n < 0) n = 0;
                    if (n > CntMax) n = CntMax;
                    if (dn == 1 && c == 0) m_udf[i] <= 1;
                    if (acc == 1 && dn == 0 && c == CntMax) m_ovf[i] <= 1;
                    m_cnt[i]   <= n;
                    m_start[i] <= enable && c == 0 && n != 0;
                    m_end[i]   <= enable && c != 0 && n == 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [NumDevs-1:0] act,
                         input logic [NumDevs-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic [NumDevs-1:0] e_s, e_e, e_b, e_o, e_u;
        for (int i = 0; i < NumDevs; i++) begin
            e_s[i] = m_start[i]; e_e[i] = m_end[i]; e_b[i] = (m_cnt[i] != 0);
            e_o[i] = m_ovf[i];   e_u[i] = m_udf[i];
        end
        check("model_start", ts_start, e_s);
        check("model_end", ts_end, e_e);
        check("model_busy", busy, e_b);
        check("model_ovf", err_ovf, e_o);
        check("model_udf", err_udf, e_u);
        check1("start_end_exclusive", |(ts_start & ts_end), 1'b0);
    end

    // Advance one cycle; inputs and outputs are stable at posedge + 2.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; clear = 1'b0;
        cmd_valid = '0; cmd_ready = '1; done = '0;
        #1;
        check("reset_start", ts_start, '0);
        check("reset_busy", busy, '0);
        check("reset_errs", err_ovf | err_udf, '0);
        idle(3);
        rst_n = 1'b1;
        idle(2);
        check("after_release", ts_start | ts_end | busy, '0);

        // Single job on ch0
        cmd_valid[0] = 1; tick(); cmd_valid[0] = 0;
        check1("c0_start", ts_start[0], 1'b1);
        check1("c0_busy", busy[0], 1'b1);
        tick();
        check1("c0_start_once", ts_start[0], 1'b0);
        idle(8);
        check1("c0_busy_mid", busy[0], 1'b1);
        done[0] = 1; tick(); done[0] = 0;
        check1("c0_end", ts_end[0], 1'b1);
        check1("c0_idle", busy[0], 1'b0);
        tick();
        check1("c0_end_once", ts_end[0], 1'b0);

        // Ch1: three accepts then three dones
        cmd_valid[1] = 1; tick();
        check1("c1_start", ts_start[1], 1'b1);
        tick();
        check1("c1_no_restart", ts_start[1], 1'b0);
        tick(); cmd_valid[1] = 0;
        idle(4);
        done[1] = 1; tick();
        check1("c1_busy_after1", busy[1], 1'b1);
        tick();
        check1("c1_no_early_end", ts_end[1], 1'b0);
        tick(); done[1] = 0;
        check1("c1_end", ts_end[1], 1'b1);
        check1("c1_idle", busy[1], 1'b0);
        tick();

        // Ch2 saturation, ch3 underflow
        cmd_valid[2] = 1;
        idle(16);
        cmd_valid[2] = 0;
        check1("c2_ovf", err_ovf[2], 1'b1);
        check1("c2_busy", busy[2], 1'b1);
        done[3] = 1; tick(); done[3] = 0;
        check1("c3_udf", err_udf[3], 1'b1);
        check1("c3_no_end", ts_end[3], 1'b0);
        idle(3);
        check1("c2_ovf_sticky", err_ovf[2], 1'b1);

        // Ch0 simultaneous accept and done
        cmd_valid[0] = 1; tick();
        done[0] = 1; tick();
        check("c0_same_cycle_no_pulse", ts_start | ts_end, '0);
        check1("c0_same_cycle_busy", busy[0], 1'b1);
        cmd_valid[0] = 0; tick(); done[0] = 0;
        check1("c0_end2", ts_end[0], 1'b1);
        cmd_valid[0] = 1; done[0] = 1; tick(); cmd_valid[0] = 0; done[0] = 0;
        check1("c0_zero_same_start", ts_start[0], 1'b1);
        check1("c0_zero_same_udf", err_udf[0], 1'b1);
        done[0] = 1; tick(); done[0] = 0;

        // Enable low across a busy period on ch1
        enable = 0;
        cmd_valid[1] = 1; tick(); cmd_valid[1] = 0;
        check1("dis_no_start", ts_start[1], 1'b0);
        check1("dis_busy", busy[1], 1'b1);
        idle(2);
        done[1] = 1; tick(); done[1] = 0;
        check1("dis_no_end", ts_end[1], 1'b0);
        check1("dis_idle", busy[1], 1'b0);
        enable = 1;

        // Clear during busy on ch0
        cmd_valid[0] = 1; tick(); cmd_valid[0] = 0;
        check1("clr_pre_busy", busy[0], 1'b1);
        clear = 1; tick(); clear = 0;
        check("clr_all_zero", ts_start | ts_end | busy | err_ovf | err_udf, '0);
        tick();
        check1("clr_no_end", ts_end[0], 1'b0);

        // Async reset mid-cycle while ch0 busy
        cmd_valid[0] = 1; tick(); cmd_valid[0] = 0;
        check1("rst_pre_busy", busy[0], 1'b1);
        #1 rst_n = 0;
        #1;
        check("rst_async_zero", ts_start | ts_end | busy | err_ovf | err_udf, '0);
        idle(2);
        rst_n = 1;
        idle(2);
        check1("rst_no_end", ts_end[0], 1'b0);
        cmd_valid[0] = 1; tick(); cmd_valid[0] = 0;
        check1("rst_fresh_start", ts_start[0], 1'b1);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
